// File: rtl/ps2_key_pkg.sv
// rtl/ps2_key_pkg.sv - shared types and constants for the PS/2 key receiver
package ps2_key_pkg;

  localparam int         KEY_W      = 10;
  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_key_rx_if.sv
// rtl/ps2_key_rx_if.sv - IO bus side of the PS/2 key receiver (pop strobe, head word, status)
interface ps2_key_rx_if;
  import ps2_key_pkg::*;

  logic             rd;
  logic [KEY_W-1:0] key;
  logic             ready;
  logic             overflow;

  modport master (output rd, input key, ready, overflow);
  modport slave  (input rd, output key, ready, overflow);

endinterface

// File: rtl/ps2_key_fifo.sv
// rtl/ps2_key_fifo.sv - key word buffer; FIFO when PS2_KEY_FIFO_EN is defined, else one holding register
module ps2_key_fifo
  import ps2_key_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [KEY_W-1:0] din,
  input  logic             pop,
  output logic [KEY_W-1:0] dout,
  output logic             empty,
  output logic             full
);

`ifdef PS2_KEY_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [KEY_W-1:0] mem_q [FIFO_DEPTH];
  logic [KEY_W-1:0] mem_d [FIFO_DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en = pop && !empty;
  // A pop frees the slot in the same cycle, so push-while-full is accepted alongside it.
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (wr_en) begin
      wr_ptr_d                  = wr_ptr_q + (AW+1)'(1);
      mem_d[wr_ptr_q[AW-1:0]]   = din;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
`else
  logic [KEY_W-1:0] hold_q, hold_d;
  logic             valid_q, valid_d;
  logic             unused_depth;

  assign unused_depth = FIFO_DEPTH[0];
  assign empty        = !valid_q;
  assign full         = valid_q;
  assign dout         = hold_q;

  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    if (pop) begin
      valid_d = 1'b0;
    end
    if (push) begin
      hold_d  = din;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      valid_q <= valid_d;
    end
  end
`endif

endmodule

// File: rtl/ps2_key_rx.sv
// rtl/ps2_key_rx.sv - PS/2 keyboard frame receiver and scan-code decoder; PS2_KEY_FIFO_EN selects the FIFO buffer
module ps2_key_rx
  import ps2_key_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  ps2_key_rx_if.slave  bus
);

  localparam int             TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [2:0]       clk_sync_q, clk_sync_d;
  logic [2:0]       dat_sync_q, dat_sync_d;
  rx_state_e        state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_ok_q, par_ok_d;
  logic             brk_q, brk_d;
  logic             ext_q, ext_d;
  logic [TW-1:0]    to_cnt_q, to_cnt_d;
  logic             ovf_q, ovf_d;

  logic             fall;
  logic             data_bit;
  logic             push;
  logic [KEY_W-1:0] push_key;
  logic             pop;
  logic             drop;
  logic [KEY_W-1:0] fifo_dout;
  logic             fifo_empty;
  logic             fifo_full;

  assign clk_sync_d = {clk_sync_q[1:0], ps2_clk};
  assign dat_sync_d = {dat_sync_q[1:0], ps2_data};
  // Stage 1 is the synced line, stage 2 its previous value.
  assign fall       = clk_sync_q[2] && !clk_sync_q[1];
  assign data_bit   = dat_sync_q[2];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    brk_d     = brk_q;
    ext_d     = ext_q;
    to_cnt_d  = '0;
    push      = 1'b0;
    push_key  = {brk_q, ext_q, shift_q};

    if (state_q != ST_IDLE && !fall) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end

    if (fall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!data_bit) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {data_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          par_ok_d = odd_parity_ok(shift_q, data_bit);
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (data_bit && par_ok_q) begin
            if (shift_q == PREFIX_EXT) begin
              ext_d = 1'b1;
            end else if (shift_q == PREFIX_BRK) begin
              brk_d = 1'b1;
            end else begin
              push  = 1'b1;
              brk_d = 1'b0;
              ext_d = 1'b0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && to_cnt_q == TO_LAST) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
      to_cnt_d  = '0;
    end
  end

  assign pop  = bus.rd && !fifo_empty;
  // In register mode full == ready, so this also covers an overwrite of an unread key.
  assign drop = push && fifo_full && !pop;

  always_comb begin
    ovf_d = ovf_q;
    if (pop) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 3'b111;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_ok_q   <= 1'b0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      to_cnt_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_ok_q   <= par_ok_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      to_cnt_q   <= to_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  ps2_key_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_key),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bus.key      = fifo_empty ? '0 : fifo_dout;
  assign bus.ready    = !fifo_empty;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb/tb_ps2_key_rx.sv - self-checking bench for ps2_key_rx (frame table, timeout, overflow, reset)
module tb_ps2_key_rx;
  import ps2_key_pkg::*;

  localparam int HALF  = 10;
  localparam int TMO   = 300;
  localparam int DEPTH = 8;

  typedef struct {
    logic [7:0] code;
    bit         par_err;
    bit         stop_err;
    bit         exp_push;
    logic [9:0] exp_key;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  int errors = 0;
  int checks = 0;
  logic [9:0] sb_q[$];
  logic rdy_pre;
  logic rdy_post;
  vec_t vecs[13];

  ps2_key_rx_if bus ();

  ps2_key_rx #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // The stop edge reaches the FSM two clocks after the raw fall; the push lands on the third.
  task automatic ps2_bit(input logic b, input bit last);
    ps2_data = b;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    if (last) begin
      repeat (3) @(negedge clk);
      rdy_pre = bus.ready;
      @(negedge clk);
      rdy_post = bus.ready;
    end
    wait_clk(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit par_err, input bit stop_err);
    logic par;
    par = ~(^code) ^ par_err;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i], 1'b0);
    ps2_bit(par, 1'b0);
    ps2_bit(~stop_err, 1'b1);
    ps2_data = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic send_partial();
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
  endtask

  task automatic read_key(input string name);
    @(negedge clk);
    check({name, " ready"}, bus.ready, 1);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s key: got %0h with nothing queued, required no word", name, bus.key);
    end else begin
      check({name, " key"}, bus.key, sb_q.pop_front());
    end
    @(posedge clk);
    #1 bus.rd = 1'b1;
    @(posedge clk);
    #1 bus.rd = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{8'h1D, 0, 0, 1, 10'h01D};
    vecs[1]  = '{8'hE0, 0, 0, 0, 10'h000};
    vecs[2]  = '{8'hF0, 0, 0, 0, 10'h000};
    vecs[3]  = '{8'h75, 0, 0, 1, 10'h375};
    vecs[4]  = '{8'h1C, 1, 0, 0, 10'h000};
    vecs[5]  = '{8'h1C, 0, 0, 1, 10'h01C};
    vecs[6]  = '{8'hF0, 0, 0, 0, 10'h000};
    vecs[7]  = '{8'h1D, 0, 0, 1, 10'h21D};
    vecs[8]  = '{8'hE0, 0, 0, 0, 10'h000};
    vecs[9]  = '{8'h6B, 0, 0, 1, 10'h16B};
    vecs[10] = '{8'h55, 0, 1, 0, 10'h000};
    vecs[11] = '{8'h00, 0, 0, 1, 10'h000};
    vecs[12] = '{8'hFF, 0, 0, 1, 10'h0FF};

    bus.rd = 1'b0;
    wait_clk(5);
    @(negedge clk);
    check("reset key", bus.key, 0);
    check("reset ready", bus.ready, 0);
    check("reset overflow", bus.overflow, 0);
    rst = 1'b0;
    wait_clk(5);

    for (int i = 0; i < 13; i++) begin
      send_frame(vecs[i].code, vecs[i].par_err, vecs[i].stop_err);
      if (vecs[i].exp_push) sb_q.push_back(vecs[i].exp_key);
      check($sformatf("v%0d ready before push", i), rdy_pre, 0);
      check($sformatf("v%0d ready after stop", i), rdy_post, vecs[i].exp_push);
      if (rdy_post) read_key($sformatf("v%0d", i));
      @(negedge clk);
      check($sformatf("v%0d ready after rd", i), bus.ready, 0);
    end
    check("table overflow", bus.overflow, 0);

    @(posedge clk);
    #1 bus.rd = 1'b1;
    @(posedge clk);
    #1 bus.rd = 1'b0;
    @(negedge clk);
    check("empty rd ready", bus.ready, 0);
    check("empty rd overflow", bus.overflow, 0);

    send_partial();
    wait_clk(TMO + 20);
    send_frame(8'h23, 0, 0);
    sb_q.push_back(10'h023);
    check("timeout ready", rdy_post, 1);
    read_key("timeout");
    @(negedge clk);
    check("timeout single word", bus.ready, 0);

`ifdef PS2_KEY_FIFO_EN
    for (int i = 0; i < 9; i++) begin
      send_frame(8'h10 + 8'(i), 0, 0);
      if (i < 8) sb_q.push_back(10'h010 + 10'(i));
    end
    @(negedge clk);
    check("fifo overflow set", bus.overflow, 1);
    read_key("fifo0");
    @(negedge clk);
    check("fifo overflow cleared", bus.overflow, 0);
    for (int i = 1; i < 8; i++) read_key($sformatf("fifo%0d", i));
    @(negedge clk);
    check("fifo drained", bus.ready, 0);
`else
    send_frame(8'h2A, 0, 0);
    send_frame(8'h3B, 0, 0);
    sb_q.push_back(10'h03B);
    @(negedge clk);
    check("hold overflow set", bus.overflow, 1);
    read_key("hold");
    @(negedge clk);
    check("hold overflow cleared", bus.overflow, 0);
    check("hold drained", bus.ready, 0);
`endif

    send_frame(8'h2A, 0, 0);
    send_frame(8'h3B, 0, 0);
    send_partial();
    @(negedge clk);
    check("pre-reset ready", bus.ready, 1);
    rst = 1'b1;
    #1;
    check("mid reset key", bus.key, 0);
    check("mid reset ready", bus.ready, 0);
    check("mid reset overflow", bus.overflow, 0);
    sb_q.delete();
    wait_clk(3);
    rst = 1'b0;
    wait_clk(5);
    send_frame(8'h1B, 0, 0);
    sb_q.push_back(10'h01B);
    check("post reset ready", rdy_post, 1);
    read_key("post reset");
    @(negedge clk);
    check("post reset drained", bus.ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_rx.md
PS2_KEY_RX -- requirements
Module: ps2_key_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, power-of-two count of buffered key words.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 100000, clk cycles without a PS/2 falling edge before an open frame is abandoned.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port ps2_clk, input, 1, raw asynchronous PS/2 clock line.
REQ-006 SHALL have port ps2_data, input, 1, raw asynchronous PS/2 data line.
REQ-007 SHALL have port rd, input, 1, pop strobe from the IO bus, one cycle per key.
REQ-008 SHALL have port key, output, 10, head key word {brk, ext, code[7:0]}.
REQ-009 SHALL have port ready, output, 1, high while at least one key word is buffered.
REQ-010 SHALL have port overflow, output, 1, sticky: a completed key was dropped.

Function
REQ-011 SHALL pass ps2_clk and ps2_data through 3-flop synchronizers; falling edge = previous synced high, current synced low.
REQ-012 SHALL run FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, advancing only on a synced falling edge.
REQ-013 IDLE: sampled data 0 moves to DATA with bit count 0; sampled 1 stays in IDLE.
REQ-014 DATA: SHALL shift in 8 bits LSB first, moving to PARITY after the 8th.
REQ-015 PARITY: SHALL check odd parity over 8 data bits plus parity bit; result held for STOP.
REQ-016 STOP: stop bit 1 with good parity completes the byte; any error discards it silently; both return to IDLE.
REQ-017 SHALL return to IDLE, discarding partial bits, when not in IDLE and TIMEOUT_CYC cycles pass with no falling edge.
REQ-018 Completed byte 8'hE0 SHALL set ext; 8'hF0 SHALL set brk; neither is pushed.
REQ-019 Any other completed byte SHALL push {brk, ext, byte} in the cycle the stop edge is detected, then clear brk and ext.
REQ-020 key and ready SHALL reflect a push into an empty buffer on the next clk cycle (first-word fall-through).
REQ-021 rd while ready SHALL pop the head; rd while empty SHALL be ignored.
REQ-022 A push while full without rd that cycle SHALL be dropped and set overflow.
REQ-023 A push and a pop in the same cycle while full SHALL both take effect, without setting overflow.
REQ-024 overflow SHALL clear on any accepted rd, unless the same cycle drops a push, which wins.
REQ-025 Read/write pointers SHALL use log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full = MSBs differ and low bits equal.

Reset
REQ-026 While rst is high, SHALL set FSM to IDLE, clear bit count, shift register, brk, ext, timeout counter and pointers, and hold synchronizers at 1.
REQ-027 While rst is high, key SHALL be 0, ready 0 and overflow 0.
REQ-028 A frame in progress when rst asserts SHALL be lost; reception restarts at the next start bit after release.

Configuration
REQ-029 With PS2_KEY_FIFO_EN defined, SHALL buffer FIFO_DEPTH words per REQ-020..REQ-025.
REQ-030 Without it, SHALL use a single holding register; a push overwrites it.
REQ-031 Without it, a push SHALL set overflow when ready is high and rd is low that cycle; FIFO_DEPTH is then ignored.

Structure
REQ-032 SHALL place the FSM state enum, PREFIX_EXT=8'hE0, PREFIX_BRK=8'hF0 and KEY_W=10 in shared package ps2_key_pkg.
REQ-033 SHALL implement the buffer as sub-module ps2_key_fifo (clk, rst, push, din, pop, dout, empty, full).

Verification
REQ-034 Frame 8'h1D with good parity and stop, then rd -> key=10'h01D and ready=1 one cycle after the stop edge; ready=0 after rd.
REQ-035 Frames E0, F0, 75 -> one word key=10'h375; no word is pushed for the prefixes.
REQ-036 Frame 8'h1C with wrong parity -> no push, ready stays 0; the next good 8'h1C yields key=10'h01C.
REQ-037 Start bit plus 3 data bits, then 100000 idle cycles, then a full frame 8'h23 -> key=10'h023 only.
REQ-038 With PS2_KEY_FIFO_EN, 9 keys without rd -> overflow=1 and first 8 read back in order; the next rd clears overflow.
REQ-039 rst asserted mid-frame -> key=0, ready=0 and overflow=0 immediately; the next frame 8'h1B decodes as 10'h01B.
